// File: rtl/mby_gmm_pkg.sv
// Shared widths, watermark-update record and scheduler states for the GCM RX watermark controller.
package mby_gmm_pkg;

    localparam int unsigned N_PORTS = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PORT_W  = $clog2(N_PORTS);
    localparam int unsigned GCNT_W  = CNT_W + 4;

    typedef logic [PORT_W-1:0] port_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [GCNT_W-1:0] gcnt_t;

    localparam cnt_t CNT_MAX = '1;

    typedef struct packed {
        port_t port;
        logic  drop;
    } wm_upd_t;

    typedef enum logic {StIdle, StOffer} wm_st_e;

    function automatic port_t next_port(input port_t p);
        return (p == port_t'(N_PORTS - 1)) ? '0 : p + port_t'(1);
    endfunction

    // A degenerate window (lo >= hi) collapses to a plain threshold compare.
    function automatic logic drop_next(input cnt_t cnt, input logic drop,
                                       input cnt_t hi, input cnt_t lo);
        if (lo >= hi) return cnt >= hi;
        if (cnt >= hi) return 1'b1;
        if (cnt <= lo) return 1'b0;
        return drop;
    endfunction

endpackage

// File: rtl/mby_gcm_rx_wm_rr_arb.sv
// Round-robin picker: lowest requesting port at or after ptr_i, wrapping.
module mby_gcm_rx_wm_rr_arb
    import mby_gmm_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  port_t              ptr_i,
    output logic               gnt_valid_o,
    output port_t              gnt_port_o
);

    int unsigned idx;
    port_t       cand;

    // Scan from the far end down so the nearest requester is the last one written.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_port_o  = '0;
        idx         = 0;
        cand        = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            idx  = (int'(ptr_i) + i) % N_PORTS;
            cand = port_t'(idx);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_port_o  = cand;
            end
        end
    end

endmodule

// File: rtl/mby_gcm_rx_wm_ctrl.sv
// Per-port RX segment counters with hysteretic drop watermarks and a round-robin update offer to IGR.
// Optional global usage counter and global_drop output when MBY_GCM_RX_WM_GLOBAL_EN is defined.
module mby_gcm_rx_wm_ctrl
    import mby_gmm_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  enq_valid,
    input  port_t enq_port,
    input  logic  deq_valid,
    input  port_t deq_port,
    input  cnt_t  cfg_wm_hi,
    input  cnt_t  cfg_wm_lo,
    output logic  wm_valid,
    input  logic  wm_ready,
    output port_t wm_port,
    output logic  wm_drop,
    output logic  err_underflow
`ifdef MBY_GCM_RX_WM_GLOBAL_EN
    ,
    input  gcnt_t cfg_gwm,
    output logic  global_drop
`endif
);

    cnt_t               cnt_q [N_PORTS];
    cnt_t               cnt_d [N_PORTS];
    logic [N_PORTS-1:0] inc, dec, uflow;
    logic [N_PORTS-1:0] drop_q, drop_d, pend_q, pend_d, clr;
    logic               err_q, err_d;
    port_t              rr_q, rr_d, arb_ptr, gnt_port;
    logic               gnt_valid, load;
    wm_st_e             state_q, state_d;
    wm_upd_t            upd_q, upd_d;

    assign inc = {{(N_PORTS - 1){1'b0}}, enq_valid} << enq_port;
    assign dec = {{(N_PORTS - 1){1'b0}}, deq_valid} << deq_port;

    always_comb begin
        uflow = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            cnt_d[p] = cnt_q[p];
            if (inc[p] && !dec[p]) begin
                if (cnt_q[p] != CNT_MAX) cnt_d[p] = cnt_q[p] + 1'b1;
            end else if (dec[p] && !inc[p]) begin
                if (cnt_q[p] == '0) uflow[p] = 1'b1;
                else                cnt_d[p] = cnt_q[p] - 1'b1;
            end
            drop_d[p] = drop_next(cnt_d[p], drop_q[p], cfg_wm_hi, cfg_wm_lo);
        end
    end

    assign err_d  = err_q | (|uflow);
    // A drop change always re-arms pending, even for the port being granted this cycle.
    assign pend_d = (pend_q & ~clr) | (drop_d ^ drop_q);

    // While offering, arbitrate from past the current grant so a handshake can chain without a bubble.
    assign arb_ptr = (state_q == StOffer) ? next_port(upd_q.port) : rr_q;

    mby_gcm_rx_wm_rr_arb u_rr_arb (
        .req_i       (pend_q),
        .ptr_i       (arb_ptr),
        .gnt_valid_o (gnt_valid),
        .gnt_port_o  (gnt_port)
    );

    always_comb begin
        state_d = state_q;
        upd_d   = upd_q;
        rr_d    = rr_q;
        clr     = '0;
        load    = 1'b0;
        unique case (state_q)
            StIdle: load = gnt_valid;
            StOffer: begin
                if (wm_ready) begin
                    rr_d = next_port(upd_q.port);
                    load = gnt_valid;
                    if (!gnt_valid) state_d = StIdle;
                end
            end
        endcase
        if (load) begin
            upd_d.port    = gnt_port;
            upd_d.drop    = drop_q[gnt_port];
            clr[gnt_port] = 1'b1;
            state_d       = StOffer;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) cnt_q[p] <= '0;
            drop_q  <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
            rr_q    <= '0;
            state_q <= StIdle;
            upd_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            rr_q    <= rr_d;
            state_q <= state_d;
            upd_q   <= upd_d;
        end
    end

    assign wm_valid      = (state_q == StOffer);
    assign wm_port       = upd_q.port;
    assign wm_drop       = upd_q.drop;
    assign err_underflow = err_q;

`ifdef MBY_GCM_RX_WM_GLOBAL_EN
    gcnt_t gcnt_q, gcnt_d;
    logic  g_inc, g_dec, gdrop_q;

    // A free that underflows its port never reached the pool, so it is not subtracted globally.
    assign g_inc = |(inc & ~dec);
    assign g_dec = |(dec & ~inc & ~uflow);

    always_comb begin
        gcnt_d = gcnt_q;
        if (g_inc && !g_dec && gcnt_q != '1)      gcnt_d = gcnt_q + 1'b1;
        else if (g_dec && !g_inc && gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt_q  <= '0;
            gdrop_q <= 1'b0;
        end else begin
            gcnt_q  <= gcnt_d;
            gdrop_q <= (gcnt_d >= cfg_gwm);
        end
    end

    assign global_drop = gdrop_q;
`endif

endmodule

// File: tb/tb_mby_gcm_rx_wm_ctrl.sv
// Bench for mby_gcm_rx_wm_ctrl: directed watermark scenarios plus random traffic against a count/drop model.
module tb_mby_gcm_rx_wm_ctrl;
    import mby_gmm_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  enq_valid, deq_valid, wm_ready;
    port_t enq_port, deq_port;
    cnt_t  cfg_wm_hi, cfg_wm_lo;
    logic  wm_valid, wm_drop, err_underflow;
    port_t wm_port;
`ifdef MBY_GCM_RX_WM_GLOBAL_EN
    gcnt_t cfg_gwm = 20'd6;
    logic  global_drop;
`endif

    always #5 clk = ~clk;

    mby_gcm_rx_wm_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_port      (enq_port),
        .deq_valid     (deq_valid),
        .deq_port      (deq_port),
        .cfg_wm_hi     (cfg_wm_hi),
        .cfg_wm_lo     (cfg_wm_lo),
        .wm_valid      (wm_valid),
        .wm_ready      (wm_ready),
        .wm_port       (wm_port),
        .wm_drop       (wm_drop),
        .err_underflow (err_underflow)
`ifdef MBY_GCM_RX_WM_GLOBAL_EN
        ,
        .cfg_gwm       (cfg_gwm),
        .global_drop   (global_drop)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference state: plain integer counts, drop flags, sticky error, and IGR's view of each port.
    int    cnt_m  [N_PORTS];
    bit    drop_m [N_PORTS];
    bit    err_m;
    bit    igr    [N_PORTS];
    bit    stall_prev;
    port_t stall_port;
    logic  stall_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wm(input string tag, input logic v, input logic [3:0] p, input logic d);
        check({tag, "_valid"}, {31'd0, wm_valid}, {31'd0, v});
        if (v) begin
            check({tag, "_port"}, {28'd0, wm_port}, {28'd0, p});
            check({tag, "_drop"}, {31'd0, wm_drop}, {31'd0, d});
        end
    endtask

    function automatic void model_clear();
        for (int p = 0; p < N_PORTS; p++) begin
            cnt_m[p]  = 0;
            drop_m[p] = 1'b0;
        end
        err_m = 1'b0;
    endfunction

    function automatic void model_step();
        int hi, lo;
        bit e, d;
        hi = int'(cfg_wm_hi);
        lo = int'(cfg_wm_lo);
        for (int p = 0; p < N_PORTS; p++) begin
            e = enq_valid && (int'(enq_port) == p);
            d = deq_valid && (int'(deq_port) == p);
            if (e && !d && cnt_m[p] < 65535) cnt_m[p]++;
            else if (d && !e) begin
                if (cnt_m[p] == 0) err_m = 1'b1;
                else               cnt_m[p]--;
            end
            if (lo >= hi)           drop_m[p] = (cnt_m[p] >= hi);
            else if (cnt_m[p] >= hi) drop_m[p] = 1'b1;
            else if (cnt_m[p] <= lo) drop_m[p] = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        #1;
    endtask

    task automatic ev(input logic e, input port_t ep, input logic d, input port_t dp);
        enq_valid = e;
        enq_port  = ep;
        deq_valid = d;
        deq_port  = dp;
    endtask

    task automatic idle();
        ev(1'b0, '0, 1'b0, '0);
    endtask

    task automatic do_reset(input int hi, input int lo);
        idle();
        rst       = 1'b1;
        cfg_wm_hi = cnt_t'(hi);
        cfg_wm_lo = cnt_t'(lo);
        model_clear();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // IGR-side monitor: records accepted updates and checks outputs hold while stalled.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            for (int p = 0; p < N_PORTS; p++) igr[p] = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, wm_valid}, 32'd1);
                check("stall_port", {28'd0, wm_port}, {28'd0, stall_port});
                check("stall_drop", {31'd0, wm_drop}, {31'd0, stall_drop});
            end
            if (wm_valid && wm_ready) igr[wm_port] = wm_drop;
            stall_prev = wm_valid && !wm_ready;
            stall_port = wm_port;
            stall_drop = wm_drop;
        end
    end

    initial begin
        idle();
        wm_ready  = 1'b0;
        cfg_wm_hi = 16'd4;
        cfg_wm_lo = 16'd2;
        model_clear();
        #12;
        expect_wm("rst", 1'b0, 4'd0, 1'b0);
        check("rst_port", {28'd0, wm_port}, 32'd0);
        check("rst_drop", {31'd0, wm_drop}, 32'd0);
        check("rst_err", {31'd0, err_underflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Four allocations to port 3 cross hi=4; update appears two cycles after the fourth.
        for (int i = 0; i < 4; i++) begin ev(1'b1, 4'd3, 1'b0, '0); tick(); end
        idle();
        expect_wm("t030_early", 1'b0, 4'd0, 1'b0);
        tick();
        expect_wm("t030_offer", 1'b1, 4'd3, 1'b1);
        tick();
        expect_wm("t030_hold", 1'b1, 4'd3, 1'b1);
        wm_ready = 1'b1;
        tick();
        expect_wm("t030_done", 1'b0, 4'd0, 1'b0);

        // Hysteresis: 3 holds the drop, 2 releases it.
        ev(1'b0, '0, 1'b1, 4'd3); tick(); idle(); tick(); tick();
        expect_wm("t031_hold", 1'b0, 4'd0, 1'b0);
        ev(1'b0, '0, 1'b1, 4'd3); tick(); idle();
        expect_wm("t031_early", 1'b0, 4'd0, 1'b0);
        tick();
        expect_wm("t031_offer", 1'b1, 4'd3, 1'b0);
        tick();
        expect_wm("t031_done", 1'b0, 4'd0, 1'b0);

        // Port 1 granted last leaves the pointer at 2, so 5 goes before 1 when both cross together.
        for (int i = 0; i < 4; i++) begin ev(1'b1, 4'd1, 1'b0, '0); tick(); end
        idle(); tick(); tick(); tick();
        check("t032_igr1", {31'd0, igr[1]}, 32'd1);
        ev(1'b0, '0, 1'b1, 4'd1); tick();
        for (int i = 0; i < 3; i++) begin ev(1'b1, 4'd5, 1'b0, '0); tick(); end
        idle(); tick(); tick();
        expect_wm("t032_quiet", 1'b0, 4'd0, 1'b0);
        wm_ready = 1'b0;
        ev(1'b1, 4'd5, 1'b1, 4'd1); tick(); idle();
        expect_wm("t032_early", 1'b0, 4'd0, 1'b0);
        tick();
        expect_wm("t032_first", 1'b1, 4'd5, 1'b1);
        repeat (5) tick();
        expect_wm("t032_held", 1'b1, 4'd5, 1'b1);
        wm_ready = 1'b1;
        tick();
        expect_wm("t032_second", 1'b1, 4'd1, 1'b0);
        tick();
        expect_wm("t032_done", 1'b0, 4'd0, 1'b0);

        // Simultaneous enq+deq leaves port 0 at 3, so one more allocation crosses.
        for (int i = 0; i < 3; i++) begin ev(1'b1, 4'd0, 1'b0, '0); tick(); end
        for (int i = 0; i < 10; i++) begin ev(1'b1, 4'd0, 1'b1, 4'd0); tick(); end
        idle(); tick(); tick(); tick();
        expect_wm("t033_quiet", 1'b0, 4'd0, 1'b0);
        check("t033_err0", {31'd0, err_underflow}, 32'd0);
        ev(1'b1, 4'd0, 1'b0, '0); tick(); idle(); tick();
        expect_wm("t033_cross", 1'b1, 4'd0, 1'b1);
        tick();
        ev(1'b0, '0, 1'b1, 4'd7); tick(); idle();
        check("t033_err1", {31'd0, err_underflow}, 32'd1);
        for (int i = 0; i < 4; i++) begin ev(1'b1, 4'd7, 1'b0, '0); tick(); end
        idle();
        expect_wm("t033_p7_early", 1'b0, 4'd0, 1'b0);
        tick();
        expect_wm("t033_p7", 1'b1, 4'd7, 1'b1);
        tick();

        // Reset mid-offer clears outputs at once; events during reset are dropped.
        wm_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin ev(1'b1, 4'd2, 1'b0, '0); tick(); end
        idle(); tick();
        expect_wm("t034_pre", 1'b1, 4'd2, 1'b1);
        ev(1'b1, 4'd9, 1'b0, '0);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("t034_valid", {31'd0, wm_valid}, 32'd0);
        check("t034_port", {28'd0, wm_port}, 32'd0);
        check("t034_drop", {31'd0, wm_drop}, 32'd0);
        check("t034_err", {31'd0, err_underflow}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        idle();
        wm_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_wm("t034_after", 1'b0, 4'd0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin ev(1'b1, 4'd2, 1'b0, '0); tick(); end
        idle(); tick();
        expect_wm("t034_recount", 1'b1, 4'd2, 1'b1);
        tick();

        // Random traffic, hysteretic then degenerate window; IGR view must converge on the model.
        for (int c = 0; c < 2; c++) begin
            do_reset((c == 0) ? 5 : 3, (c == 0) ? 2 : 6);
            for (int n = 0; n < 1500; n++) begin
                ev(1'($urandom % 2), port_t'($urandom % 4), 1'($urandom % 2),
                   port_t'($urandom % 4));
                wm_ready = ($urandom % 3) != 0;
                tick();
                check("rnd_err", {31'd0, err_underflow}, {31'd0, err_m});
            end
            idle();
            wm_ready = 1'b1;
            repeat (40) tick();
            expect_wm("rnd_drained", 1'b0, 4'd0, 1'b0);
            for (int p = 0; p < N_PORTS; p++)
                check($sformatf("rnd_igr_p%0d", p), {31'd0, igr[p]}, {31'd0, drop_m[p]});
        end

`ifdef MBY_GCM_RX_WM_GLOBAL_EN
        cfg_gwm = 20'd6;
        do_reset(100, 50);
        for (int i = 0; i < 5; i++) begin ev(1'b1, port_t'(i % 3), 1'b0, '0); tick(); end
        idle();
        check("g_below", {31'd0, global_drop}, 32'd0);
        ev(1'b1, 4'd2, 1'b0, '0); tick(); idle();
        check("g_set", {31'd0, global_drop}, 32'd1);
        ev(1'b0, '0, 1'b1, 4'd0); tick(); idle();
        check("g_clr", {31'd0, global_drop}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
